pipe_hazard_ctrl: RTL and testbench

- Pipeline stall/flush controller for the 5-stage MIPS pipeline. It is the counterpart to the operand-forwarding logic: the forwarding unit covers the hazards that can be bypassed, and this block covers the ones that cannot.
- Hazards handled: load-use hazards (inserts bubbles), taken branches and jumps (squashes wrong-path instructions), and memory wait states (freezes the pipe while data memory is not ready).
- Drives the write-enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps a stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 95 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for load-use, taken-branch, jump and data-memory wait hazards
module pipe_hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEXMemRd,
  input  logic [4:0]       IDEXRt,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic             IFIDUseRt,
  input  logic             IDJump,
  input  logic             EXBranchTaken,
  input  logic             EXMEMMemReq,
  input  logic             MemReady,
  output logic             PCWr,
  output logic             IFIDWr,
  output logic             IFIDFlush,
  output logic             IDEXWr,
  output logic             IDEXFlush,
  output logic             EXMEMWr,
  output logic             MEMWBFlush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  state_t state_q, state_d, saved_q, saved_d, eff;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic mem_timeout_q, mem_timeout_d, rel_q, rel_d;
  logic mem_wait, lu_hz, lu_out, tmo;
  assign eff = (state_q == MEM_WAIT) ? saved_q : state_q;
  // rel_q masks the wait for one cycle so a timeout releases exactly like MemReady
  assign mem_wait = EXMEMMemReq & ~MemReady & ~rel_q;
  assign lu_hz = IDEXMemRd && (IDEXRt != 5'd0) &&
                 ((IDEXRt == IFIDRs) || (IFIDUseRt && (IDEXRt == IFIDRt)));
  assign lu_out = (eff == LU_STALL) || ((eff == RUN) && lu_hz);
  assign tmo = mem_wait && (wait_cnt_q == 16'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      saved_q       <= RUN;
      lu_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
      rel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_q       <= saved_d;
      lu_cnt_q      <= lu_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      rel_q         <= rel_d;
    end
  end
  always_comb begin
    state_d       = RUN;
    saved_d       = saved_q;
    lu_cnt_d      = lu_cnt_q;
    wait_cnt_d    = '0;
    rel_d         = 1'b0;
    mem_timeout_d = mem_timeout_q | tmo;
    stall_cnt_d   = (!PCWr && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    if (mem_wait) begin
      state_d    = MEM_WAIT;
      saved_d    = eff;
      wait_cnt_d = tmo ? '0 : wait_cnt_q + 16'd1;
      rel_d      = tmo;
    end else if (EXBranchTaken) begin
      lu_cnt_d = '0;
    end else if (eff == LU_STALL) begin
      lu_cnt_d = lu_cnt_q - 2'd1;
      state_d  = (lu_cnt_q == 2'd1) ? RUN : LU_STALL;
    end else if (lu_hz && LOAD_BUBBLES > 1) begin
      state_d  = LU_STALL;
      lu_cnt_d = 2'(LOAD_BUBBLES - 1);
    end
  end
  // {PCWr, IFIDWr, IFIDFlush, IDEXWr, IDEXFlush, EXMEMWr, MEMWBFlush}
  always_comb begin
    {PCWr, IFIDWr, IFIDFlush, IDEXWr, IDEXFlush, EXMEMWr, MEMWBFlush} =
      reset         ? 7'b0010101 :
      mem_wait      ? 7'b0000001 :
      EXBranchTaken ? 7'b1111110 :
      lu_out        ? 7'b0001110 :
      IDJump        ? 7'b1110010 : 7'b1101010;
  end
  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario tests for pipe_hazard_ctrl across three parameter sets
module tb_pipe_hazard_ctrl;
  localparam logic [6:0] RUN_O = 7'b1101010;
  localparam logic [6:0] RST_O = 7'b0010101;
  localparam logic [6:0] MW_O  = 7'b0000001;
  localparam logic [6:0] BR_O  = 7'b1111110;
  localparam logic [6:0] LU_O  = 7'b0001110;
  localparam logic [6:0] JMP_O = 7'b1110010;

  logic clk = 1'b0, reset = 1'b1;
  logic IDEXMemRd, IFIDUseRt, IDJump, EXBranchTaken, EXMEMMemReq, MemReady;
  logic [4:0] IDEXRt, IFIDRs, IFIDRt;
  logic pc1, ifw1, iff1, idw1, idf1, exw1, mwf1, to1;
  logic pc2, ifw2, iff2, idw2, idf2, exw2, mwf2, to2;
  logic pc3, ifw3, iff3, idw3, idf3, exw3, mwf3, to3;
  logic [15:0] sc1, sc2;
  logic [1:0] sc3;
  logic [6:0] o1, o2;
  int errors = 0, checks = 0;

  assign o1 = {pc1, ifw1, iff1, idw1, idf1, exw1, mwf1};
  assign o2 = {pc2, ifw2, iff2, idw2, idf2, exw2, mwf2};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .IDEXMemRd(IDEXMemRd), .IDEXRt(IDEXRt), .IFIDRs(IFIDRs),
    .IFIDRt(IFIDRt), .IFIDUseRt(IFIDUseRt), .IDJump(IDJump), .EXBranchTaken(EXBranchTaken),
    .EXMEMMemReq(EXMEMMemReq), .MemReady(MemReady), .PCWr(pc1), .IFIDWr(ifw1),
    .IFIDFlush(iff1), .IDEXWr(idw1), .IDEXFlush(idf1), .EXMEMWr(exw1), .MEMWBFlush(mwf1),
    .stall_cnt(sc1), .mem_timeout(to1));

  pipe_hazard_ctrl #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .IDEXMemRd(IDEXMemRd), .IDEXRt(IDEXRt), .IFIDRs(IFIDRs),
    .IFIDRt(IFIDRt), .IFIDUseRt(IFIDUseRt), .IDJump(IDJump), .EXBranchTaken(EXBranchTaken),
    .EXMEMMemReq(EXMEMMemReq), .MemReady(MemReady), .PCWr(pc2), .IFIDWr(ifw2),
    .IFIDFlush(iff2), .IDEXWr(idw2), .IDEXFlush(idf2), .EXMEMWr(exw2), .MEMWBFlush(mwf2),
    .stall_cnt(sc2), .mem_timeout(to2));

  pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .IDEXMemRd(IDEXMemRd), .IDEXRt(IDEXRt), .IFIDRs(IFIDRs),
    .IFIDRt(IFIDRt), .IFIDUseRt(IFIDUseRt), .IDJump(IDJump), .EXBranchTaken(EXBranchTaken),
    .EXMEMMemReq(EXMEMMemReq), .MemReady(MemReady), .PCWr(pc3), .IFIDWr(ifw3),
    .IFIDFlush(iff3), .IDEXWr(idw3), .IDEXFlush(idf3), .EXMEMWr(exw3), .MEMWBFlush(mwf3),
    .stall_cnt(sc3), .mem_timeout(to3));

  task automatic idle();
    IDEXMemRd = 0; IDEXRt = 0; IFIDRs = 0; IFIDRt = 0; IFIDUseRt = 0;
    IDJump = 0; EXBranchTaken = 0; EXMEMMemReq = 0; MemReady = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); step(); reset = 0;
  endtask

  task automatic load_use(input logic [4:0] r);
    IDEXMemRd = 1; IDEXRt = r; IFIDRs = r;
  endtask

  task automatic test_reset();
    reset = 1; EXMEMMemReq = 1; MemReady = 0; load_use(5'd3); #1;
    checks++; if (o1 !== RST_O) begin errors++; $display("FAIL rst_out1 got %b exp %b", o1, RST_O); end
    checks++; if (o2 !== RST_O) begin errors++; $display("FAIL rst_out2 got %b exp %b", o2, RST_O); end
    step(); reset = 0; idle(); #1;
    checks++; if (o1 !== RUN_O) begin errors++; $display("FAIL rst_run got %b exp %b", o1, RUN_O); end
    checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", sc1); end
    checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL rst_to got %b exp 0", to1); end
  endtask

  task automatic test_load_use_lb1();
    do_reset(); load_use(5'd3); #1;
    checks++; if (o1 !== LU_O) begin errors++; $display("FAIL lu1_stall got %b exp %b", o1, LU_O); end
    step(); IDEXMemRd = 0; #1;
    checks++; if (o1 !== RUN_O) begin errors++; $display("FAIL lu1_after got %b exp %b", o1, RUN_O); end
    checks++; if (sc1 !== 16'd1) begin errors++; $display("FAIL lu1_cnt got %0d exp 1", sc1); end
    step(); IDEXMemRd = 1; IDEXRt = 7; IFIDRs = 2; IFIDRt = 7; IFIDUseRt = 0; #1;
    checks++; if (o1 !== RUN_O) begin errors++; $display("FAIL lu1_rt_unused got %b exp %b", o1, RUN_O); end
    IFIDUseRt = 1; #1;
    checks++; if (o1 !== LU_O) begin errors++; $display("FAIL lu1_rt_used got %b exp %b", o1, LU_O); end
  endtask

  task automatic test_load_use_lb2();
    do_reset(); load_use(5'd0); #1;
    checks++; if (o2 !== RUN_O) begin errors++; $display("FAIL lu2_r0 got %b exp %b", o2, RUN_O); end
    step(); load_use(5'd5); #1;
    checks++; if (o2 !== LU_O) begin errors++; $display("FAIL lu2_b1 got %b exp %b", o2, LU_O); end
    step(); IDEXMemRd = 0; IDJump = 1; #1;
    checks++; if (o2 !== LU_O) begin errors++; $display("FAIL lu2_b2_jump_held got %b exp %b", o2, LU_O); end
    step(); #1;
    checks++; if (o2 !== JMP_O) begin errors++; $display("FAIL lu2_jump got %b exp %b", o2, JMP_O); end
    checks++; if (sc2 !== 16'd2) begin errors++; $display("FAIL lu2_cnt got %0d exp 2", sc2); end
  endtask

  task automatic test_branch_in_bubble();
    do_reset(); load_use(5'd5); #1;
    checks++; if (o2 !== LU_O) begin errors++; $display("FAIL br_b1 got %b exp %b", o2, LU_O); end
    step(); IDEXMemRd = 0; EXBranchTaken = 1; #1;
    checks++; if (o2 !== BR_O) begin errors++; $display("FAIL br_b2 got %b exp %b", o2, BR_O); end
    step(); idle(); #1;
    checks++; if (o2 !== RUN_O) begin errors++; $display("FAIL br_after got %b exp %b", o2, RUN_O); end
    checks++; if (sc2 !== 16'd1) begin errors++; $display("FAIL br_cnt got %0d exp 1", sc2); end
  endtask

  task automatic test_mem_wait();
    do_reset(); EXMEMMemReq = 1; MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o1 !== MW_O) begin errors++; $display("FAIL mw_c%0d got %b exp %b", i, o1, MW_O); end
      step();
    end
    MemReady = 1; #1;
    checks++; if (o1 !== RUN_O) begin errors++; $display("FAIL mw_release got %b exp %b", o1, RUN_O); end
    step(); idle(); #1;
    checks++; if (sc1 !== 16'd3) begin errors++; $display("FAIL mw_cnt got %0d exp 3", sc1); end
    checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL mw_to got %b exp 0", to1); end
    checks++; if (sc3 !== 2'd3) begin errors++; $display("FAIL sat_cnt3 got %0d exp 3", sc3); end
    EXMEMMemReq = 1; step(); idle(); #1;
    checks++; if (sc1 !== 16'd4) begin errors++; $display("FAIL mw_cnt4 got %0d exp 4", sc1); end
    checks++; if (sc3 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", sc3); end
  endtask

  task automatic test_mem_resume_lu();
    do_reset(); load_use(5'd5); #1;
    checks++; if (o2 !== LU_O) begin errors++; $display("FAIL res_b1 got %b exp %b", o2, LU_O); end
    step(); IDEXMemRd = 0; EXMEMMemReq = 1; MemReady = 0; #1;
    checks++; if (o2 !== MW_O) begin errors++; $display("FAIL res_wait got %b exp %b", o2, MW_O); end
    step(); MemReady = 1; #1;
    checks++; if (o2 !== LU_O) begin errors++; $display("FAIL res_b2 got %b exp %b", o2, LU_O); end
    step(); idle(); #1;
    checks++; if (o2 !== RUN_O) begin errors++; $display("FAIL res_run got %b exp %b", o2, RUN_O); end
    checks++; if (sc2 !== 16'd3) begin errors++; $display("FAIL res_cnt got %0d exp 3", sc2); end
  endtask

  task automatic test_timeout_and_reset();
    do_reset(); EXMEMMemReq = 1; MemReady = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o2 !== MW_O) begin errors++; $display("FAIL to_wait%0d got %b exp %b", i, o2, MW_O); end
      step();
    end
    #1;
    checks++; if (o2 !== RUN_O) begin errors++; $display("FAIL to_release got %b exp %b", o2, RUN_O); end
    checks++; if (to2 !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", to2); end
    step(); #1;
    checks++; if (o2 !== MW_O) begin errors++; $display("FAIL to_rewait got %b exp %b", o2, MW_O); end
    step(); idle(); #1;
    checks++; if (to2 !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", to2); end
    checks++; if (sc2 !== 16'd5) begin errors++; $display("FAIL to_cnt got %0d exp 5", sc2); end
    EXMEMMemReq = 1; step(); step(); reset = 1; #1;
    checks++; if (o2 !== RST_O) begin errors++; $display("FAIL rst_mid got %b exp %b", o2, RST_O); end
    step(); reset = 0; idle(); #1;
    checks++; if (o2 !== RUN_O) begin errors++; $display("FAIL rst_mid_run got %b exp %b", o2, RUN_O); end
    checks++; if (sc2 !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", sc2); end
    checks++; if (to2 !== 1'b0) begin errors++; $display("FAIL rst_mid_to got %b exp 0", to2); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use_lb1();
    test_load_use_lb2();
    test_branch_in_bubble();
    test_mem_wait();
    test_mem_resume_lu();
    test_timeout_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
